// File: rtl/io_responder.sv
// io_responder: CPU I/O-window responder with UART TX/RX FIFOs, cycle counter and halt; IO_STAT_EN adds a status byte at 0x30008
module io_responder #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  io_din,
  output logic        io_din_valid,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt_o,
  output logic        tx_overflow_o
);
  localparam logic [TX_DEPTH_LOG2:0] TX_CAP = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0] RX_CAP = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
  localparam logic [TX_DEPTH_LOG2:0] MARGIN = FULL_MARGIN[TX_DEPTH_LOG2:0];
  logic [7:0] tx_mem [2**TX_DEPTH_LOG2];
  logic [7:0] rx_mem [2**RX_DEPTH_LOG2];
  logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [TX_DEPTH_LOG2:0] tx_count, tx_free;
  logic [RX_DEPTH_LOG2:0] rx_count, rx_count_next;
  logic [31:0] cnt, snap;
  logic [15:0] off;
  logic access, wr_en, rd_en, tx_full, rx_nonempty;
  logic tx_req, tx_push, tx_pop, rx_push, rx_pop, stat_hit;
  logic [7:0] tx_wdata, rd_val, stat_val;
  logic unused_bits;
  assign unused_bits = &{1'b0, mem_a[31:18]};
  assign off = mem_a[15:0];
  assign access = rdy_in && mem_a[17:16] == 2'b11;
  assign wr_en = access && mem_wr;
  assign rd_en = access && !mem_wr;
  assign tx_full = tx_count == TX_CAP;
  assign rx_nonempty = rx_count != '0;
  assign tx_valid = tx_count != '0;
  assign tx_data = tx_valid ? tx_mem[tx_rp] : 8'h00;
  assign tx_free = TX_CAP - tx_count;
  assign io_buffer_full = tx_free <= MARGIN;
  // a zero byte at 0x30000 is a no-op; the stop register emits a 0x00 marker instead
  assign tx_req = wr_en && ((off == 16'h0000 && mem_dout != 8'h00) || off == 16'h0004);
  assign tx_wdata = off == 16'h0004 ? 8'h00 : mem_dout;
  assign tx_pop = tx_valid && tx_ready;
  assign tx_push = tx_req && (!tx_full || tx_pop);
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop = rd_en && off == 16'h0000 && rx_nonempty;
  assign rx_count_next = rx_count + (RX_DEPTH_LOG2+1)'(rx_push) - (RX_DEPTH_LOG2+1)'(rx_pop);
  assign stat_val = {6'b0, tx_full, rx_nonempty};
`ifdef IO_STAT_EN
  assign stat_hit = off == 16'h0008;
`else
  assign stat_hit = 1'b0;
`endif
  // byte 0 reads the live counter while the snapshot captures all four bytes for coherent follow-up reads
  assign rd_val = off == 16'h0000 ? (rx_nonempty ? rx_mem[rx_rp] : 8'h00) :
                  off == 16'h0004 ? cnt[7:0] :
                  off == 16'h0005 ? snap[15:8] :
                  off == 16'h0006 ? snap[23:16] :
                  off == 16'h0007 ? snap[31:24] :
                  stat_hit ? stat_val : 8'h00;
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp] <= tx_wdata;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt           <= '0;
      snap          <= '0;
      tx_wp         <= '0;
      tx_rp         <= '0;
      tx_count      <= '0;
      rx_wp         <= '0;
      rx_rp         <= '0;
      rx_count      <= '0;
      rx_ready      <= 1'b0;
      halt_o        <= 1'b0;
      tx_overflow_o <= 1'b0;
      io_din        <= 8'h00;
      io_din_valid  <= 1'b0;
    end else begin
      cnt      <= cnt + 32'd1;
      tx_count <= tx_count + (TX_DEPTH_LOG2+1)'(tx_push) - (TX_DEPTH_LOG2+1)'(tx_pop);
      rx_count <= rx_count_next;
      rx_ready <= rx_count_next != RX_CAP;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (wr_en && off == 16'h0004) halt_o <= 1'b1;
      if (tx_req && tx_full && !tx_pop) tx_overflow_o <= 1'b1;
      if (rd_en && off == 16'h0004) snap <= cnt;
      io_din       <= rd_en ? rd_val : 8'h00;
      io_din_valid <= rd_en;
    end
  end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed checks of io_responder bus decode, FIFOs, counter snapshot, halt and reset
module tb_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, rx_data;
  logic [7:0]  io_din, tx_data;
  logic        io_din_valid, io_buffer_full, tx_valid, rx_ready, halt_o, tx_overflow_o;
  int checks = 0;
  int failures = 0;
  logic [7:0] txq[$];
  logic [7:0] d;
  logic       v;
  io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .io_din(io_din), .io_din_valid(io_din_valid),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .halt_o(halt_o), .tx_overflow_o(tx_overflow_o)
  );
  always #5 clk_in = ~clk_in;
  always begin
    @(negedge clk_in);
    #1;
    if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cpu_wr(input logic [31:0] a, input logic [7:0] b);
    rdy_in = 1'b1; mem_a = a; mem_wr = 1'b1; mem_dout = b;
    @(negedge clk_in);
    rdy_in = 1'b0; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
  endtask
  task automatic cpu_rd(input logic [31:0] a, output logic [7:0] q, output logic qv);
    rdy_in = 1'b1; mem_a = a; mem_wr = 1'b0;
    @(negedge clk_in);
    q = io_din; qv = io_din_valid;
    rdy_in = 1'b0; mem_a = '0;
  endtask
  initial begin
    rst_in = 1'b1; rdy_in = 1'b0; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk_in);
    check("reset_outs", {io_din, io_din_valid, io_buffer_full, tx_valid, tx_data, rx_ready, halt_o, tx_overflow_o}, '0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rx_ready_up", rx_ready, 1);
    // 1: zero byte suppressed
    tx_ready = 1'b1;
    cpu_wr(32'h30000, 8'h41);
    cpu_wr(32'h30000, 8'h00);
    cpu_wr(32'h30000, 8'h42);
    repeat (3) @(negedge clk_in);
    check("t1_len", txq.size(), 2);
    check("t1_b0", txq[0], 8'h41);
    check("t1_b1", txq[1], 8'h42);
    check("t1_ovf", tx_overflow_o, 0);
    // 2: fill, nearly-full flag, overflow, drain order
    tx_ready = 1'b0;
    txq.delete();
    for (int i = 1; i <= 16; i++) begin
      cpu_wr(32'h30000, 8'(i));
      if (i == 13) check("t2_full13", io_buffer_full, 0);
      if (i == 14) check("t2_full14", io_buffer_full, 1);
    end
    check("t2_ovf16", tx_overflow_o, 0);
    cpu_wr(32'h30000, 8'd17);
    check("t2_ovf17", tx_overflow_o, 1);
    tx_ready = 1'b1;
    repeat (20) @(negedge clk_in);
    check("t2_len", txq.size(), 16);
    check("t2_first", txq[0], 8'd1);
    check("t2_last", txq[15], 8'd16);
    check("t2_empty", {tx_valid, io_buffer_full}, 0);
    // 3: RX FIFO reads, empty returns zero
    rx_valid = 1'b1; rx_data = 8'h55;
    @(negedge clk_in);
    rx_data = 8'hAA;
    @(negedge clk_in);
    rx_valid = 1'b0;
    cpu_rd(32'h30000, d, v);
    check("t3_rd0", {v, d}, {1'b1, 8'h55});
    cpu_rd(32'h30000, d, v);
    check("t3_rd1", {v, d}, {1'b1, 8'hAA});
    cpu_rd(32'h30000, d, v);
    check("t3_rd2", {v, d}, {1'b1, 8'h00});
    @(negedge clk_in);
    check("t3_idle", {io_din_valid, io_din}, 0);
    // 4: counter snapshot coherence across the 0xFF->0x100 carry
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (255) @(negedge clk_in);
    cpu_rd(32'h30004, d, v);
    check("t4_b0", {v, d}, {1'b1, 8'hFF});
    cpu_rd(32'h30005, d, v);
    check("t4_b1", {v, d}, {1'b1, 8'h00});
    cpu_rd(32'h30006, d, v);
    check("t4_b2", d, 8'h00);
    cpu_rd(32'h30007, d, v);
    check("t4_b3", d, 8'h00);
    cpu_rd(32'h30004, d, v);
    check("t4_live", d, 8'h03);
    // 5: halt, marker byte, service after halt, reset mid-stream
    tx_ready = 1'b0;
    txq.delete();
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clk_in);
    rx_valid = 1'b0;
    cpu_wr(32'h30004, 8'h5A);
    check("t5_halt", halt_o, 1);
    check("t5_marker", {tx_valid, tx_data}, {1'b1, 8'h00});
    cpu_wr(32'h30000, 8'h43);
    cpu_wr(32'h30000, 8'h44);
    tx_ready = 1'b1;
    @(negedge clk_in);
    check("t5_sent", {txq.size() == 1, txq[0]}, {1'b1, 8'h00});
    check("t5_head", tx_data, 8'h43);
    rst_in = 1'b1; tx_ready = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("t5_rst", {halt_o, tx_valid, tx_overflow_o}, 0);
    @(negedge clk_in);
    cpu_rd(32'h30000, d, v);
    check("t5_rx_flushed", {v, d}, {1'b1, 8'h00});
    // 6: paused bus, off-window and unmapped accesses, status byte
    rdy_in = 1'b0; mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h41;
    @(negedge clk_in);
    mem_wr = 1'b0; mem_a = '0;
    check("t6_paused", tx_valid, 0);
    cpu_wr(32'h20000, 8'h41);
    check("t6_offwin", tx_valid, 0);
    cpu_wr(32'h30001, 8'h41);
    check("t6_unmapped_wr", {tx_valid, halt_o}, 0);
    cpu_rd(32'h30001, d, v);
    check("t6_unmapped_rd", {v, d}, {1'b1, 8'h00});
    rx_valid = 1'b1; rx_data = 8'h66;
    @(negedge clk_in);
    rx_valid = 1'b0;
    cpu_rd(32'h30008, d, v);
`ifdef IO_STAT_EN
    check("t6_stat", {v, d}, {1'b1, 8'h01});
`else
    check("t6_stat", {v, d}, {1'b1, 8'h00});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
